// File: rtl/data_ram_arbiter.sv
// data_ram_arbiter: shares one data_ram between port 0 (CPU load/store) and
// port 1 (debug/loader master). Each access runs IDLE -> ACCESS -> ACK, so one
// request is served at most every 3 cycles and ack is a single-cycle pulse.
// Read data is registered toward the masters.
// Build option: define ARB_ROUND_ROBIN_EN for round-robin arbitration on ties;
// leave it undefined for fixed priority (port 0 wins every tie).
module data_ram_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int SEL_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [SEL_W-1:0]  m0_sel,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_ack,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [SEL_W-1:0]  m1_sel,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_ack,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              ram_ce,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [SEL_W-1:0]  ram_sel,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

`ifdef ARB_ROUND_ROBIN_EN
  localparam bit RR_EN = 1'b1;
`else
  localparam bit RR_EN = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, ACCESS, ACK} state_t;

  state_t              state, state_nxt;
  logic                take;        // IDLE with a request: latch winner this edge
  logic                grant_nxt;   // winning port if a grant happens now
  logic                gnt;         // port owning the current access
  logic                last_grant;  // port granted most recently
  logic                pay_we;
  logic [ADDR_W-1:0]   pay_addr;
  logic [SEL_W-1:0]    pay_sel;
  logic [DATA_W-1:0]   pay_wdata;

  // Arbitration: a lone requester always wins; on a tie round-robin picks the
  // port that was not granted last, fixed priority picks port 0.
  always_comb begin
    grant_nxt = ~m0_req;
    if (RR_EN && m0_req && m1_req) begin
      grant_nxt = ~last_grant;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and outputs: RAM is driven only in ACCESS, ack only in ACK.
  always_comb begin
    state_nxt = state;
    take      = 1'b0;
    ram_ce    = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_sel   = '0;
    ram_wdata = '0;
    m0_ack    = 1'b0;
    m1_ack    = 1'b0;
    case (state)
      IDLE: begin
        if (m0_req || m1_req) begin
          take      = 1'b1;
          state_nxt = ACCESS;
        end
      end
      ACCESS: begin
        ram_ce    = 1'b1;
        ram_we    = pay_we;
        ram_addr  = pay_addr;
        ram_sel   = pay_sel;
        ram_wdata = pay_wdata;
        state_nxt = ACK;
      end
      ACK: begin
        m0_ack    = ~gnt;
        m1_ack    = gnt;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Grant/payload capture at the IDLE edge and read-data capture at the end
  // of ACCESS; later master changes cannot disturb an access in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      gnt        <= 1'b0;
      last_grant <= 1'b1;
      pay_we     <= 1'b0;
      pay_addr   <= '0;
      pay_sel    <= '0;
      pay_wdata  <= '0;
      m0_rdata   <= '0;
      m1_rdata   <= '0;
    end else begin
      if (take) begin
        gnt        <= grant_nxt;
        last_grant <= grant_nxt;
        pay_we     <= grant_nxt ? m1_we    : m0_we;
        pay_addr   <= grant_nxt ? m1_addr  : m0_addr;
        pay_sel    <= grant_nxt ? m1_sel   : m0_sel;
        pay_wdata  <= grant_nxt ? m1_wdata : m0_wdata;
      end
      if (state == ACCESS && !pay_we) begin
        if (gnt) begin
          m1_rdata <= ram_rdata;
        end else begin
          m0_rdata <= ram_rdata;
        end
      end
    end
  end

endmodule

// File: tb/tb_data_ram_arbiter.sv
// Bench for data_ram_arbiter: directed scenarios plus randomized two-master
// traffic, compared every cycle against a transaction-level reference model
// (grant cycle N -> RAM access at N+1 -> ack at N+2, next grant no earlier
// than N+3) and a reference copy of memory. Honours ARB_ROUND_ROBIN_EN.
module tb_data_ram_arbiter;

`ifdef ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_v;
  logic [1:0]  we_v;
  logic [31:0] addr_v  [2];
  logic [3:0]  sel_v   [2];
  logic [31:0] wdata_v [2];
  logic        m0_ack, m1_ack;
  logic [31:0] m0_rdata, m1_rdata;
  logic        ram_ce, ram_we;
  logic [31:0] ram_addr, ram_wdata, ram_rdata;
  logic [3:0]  ram_sel;
  logic [31:0] ram_mem [64] = '{default: '0};

  data_ram_arbiter #(.ADDR_W(32), .DATA_W(32), .SEL_W(4)) dut (
    .clk(clk), .rst(rst),
    .m0_req(req_v[0]), .m0_we(we_v[0]), .m0_addr(addr_v[0]), .m0_sel(sel_v[0]),
    .m0_wdata(wdata_v[0]), .m0_ack(m0_ack), .m0_rdata(m0_rdata),
    .m1_req(req_v[1]), .m1_we(we_v[1]), .m1_addr(addr_v[1]), .m1_sel(sel_v[1]),
    .m1_wdata(wdata_v[1]), .m1_ack(m1_ack), .m1_rdata(m1_rdata),
    .ram_ce(ram_ce), .ram_we(ram_we), .ram_addr(ram_addr), .ram_sel(ram_sel),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (s[i]) r[8*i +: 8] = d[8*i +: 8];
    return r;
  endfunction

  // data_ram: combinational read, byte-lane write on the clock edge.
  assign ram_rdata = ram_mem[ram_addr[7:2]];
  always @(posedge clk) begin
    if (ram_ce && ram_we) ram_mem[ram_addr[7:2]] <= merge(ram_mem[ram_addr[7:2]], ram_wdata, ram_sel);
  end

  // Reference model state
  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc = 0;
  int          free_at = 0;
  int          acc_cyc = -1;
  int          ack_cyc = -1;
  int          win = 0;
  bit          last = 1'b1;
  bit          t_we;
  logic [31:0] t_addr, t_wdata;
  logic [3:0]  t_sel;
  logic [31:0] exp_rd [2] = '{default: '0};
  logic [31:0] ref_mem [64] = '{default: '0};
  int          ack_log[$];
  bit          busy [2] = '{default: 1'b0};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s cycle %0d got %h expected %h", tag, cyc, got, exp);
    end
  endtask

  task automatic compare_outputs();
    bit acc;
    acc = (cyc == acc_cyc);
    check("ram_ce",    32'(ram_ce),  32'(acc));
    check("ram_we",    32'(ram_we),  32'(acc && t_we));
    check("ram_addr",  ram_addr,     acc ? t_addr : 32'h0);
    check("ram_sel",   32'(ram_sel), acc ? 32'(t_sel) : 32'h0);
    check("ram_wdata", ram_wdata,    acc ? t_wdata : 32'h0);
    check("m0_ack",    32'(m0_ack),  32'(cyc == ack_cyc && win == 0));
    check("m1_ack",    32'(m1_ack),  32'(cyc == ack_cyc && win == 1));
    check("m0_rdata",  m0_rdata,     exp_rd[0]);
    check("m1_rdata",  m1_rdata,     exp_rd[1]);
    if (m0_ack) ack_log.push_back(0);
    if (m1_ack) ack_log.push_back(1);
  endtask

  // Close the current cycle in the model using the inputs now driven, then
  // advance to the next falling edge and compare.
  task automatic tick();
    if (cyc == acc_cyc) begin
      if (t_we) ref_mem[t_addr[7:2]] = merge(ref_mem[t_addr[7:2]], t_wdata, t_sel);
      else if (!rst) exp_rd[win] = ref_mem[t_addr[7:2]];
    end
    if (rst) begin
      if (acc_cyc > cyc) acc_cyc = -1;
      if (ack_cyc > cyc) ack_cyc = -1;
      free_at   = cyc + 1;
      last      = 1'b1;
      exp_rd[0] = '0;
      exp_rd[1] = '0;
    end else if (cyc >= free_at && req_v != 2'b00) begin
      if (req_v == 2'b11) win = (RR && last == 1'b0) ? 1 : 0;
      else                win = req_v[0] ? 0 : 1;
      t_we    = we_v[win];
      t_addr  = addr_v[win];
      t_sel   = sel_v[win];
      t_wdata = wdata_v[win];
      acc_cyc = cyc + 1;
      ack_cyc = cyc + 2;
      free_at = cyc + 3;
      last    = win[0];
    end
    cyc++;
    @(negedge clk);
    compare_outputs();
  endtask

  task automatic xfer(input int p, input bit we, input logic [31:0] a, input logic [3:0] s,
                      input logic [31:0] d, output int lat);
    req_v = 2'b00;
    tick();
    we_v[p] = we; addr_v[p] = a; sel_v[p] = s; wdata_v[p] = d; req_v[p] = 1'b1;
    lat = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      lat++;
      if ((p == 0) ? m0_ack : m1_ack) break;
    end
    req_v[p] = 1'b0;
  endtask

  task automatic rand_drive();
    rst = ($urandom_range(0, 59) == 0);
    for (int m = 0; m < 2; m++) begin
      logic ackd;
      ackd = (m == 0) ? m0_ack : m1_ack;
      if (rst || (busy[m] && ackd)) begin
        busy[m]  = 1'b0;
        req_v[m] = 1'b0;
      end else if (busy[m] && acc_cyc == cyc && win == m) begin
        if ($urandom_range(0, 3) == 0) begin
          addr_v[m]  = $urandom;
          wdata_v[m] = $urandom;
        end
        if ($urandom_range(0, 4) == 0) req_v[m] = 1'b0;
      end
      if (!busy[m] && !rst && $urandom_range(0, 2) == 0) begin
        we_v[m]    = 1'($urandom);
        addr_v[m]  = $urandom;
        sel_v[m]   = 4'($urandom);
        wdata_v[m] = $urandom;
        req_v[m]   = 1'b1;
        busy[m]    = 1'b1;
      end
    end
  endtask

  initial begin
    int lat;
    int exp_seq [4];
    rst = 1'b1;
    req_v = 2'b00;
    we_v = 2'b00;
    for (int m = 0; m < 2; m++) begin
      addr_v[m] = '0; sel_v[m] = '0; wdata_v[m] = '0;
    end

    // Reset held two cycles, then idle with no requests.
    tick();
    tick();
    check("t1_ce_in_reset", 32'(ram_ce), 32'h0);
    rst = 1'b0;
    repeat (3) tick();
    check("t1_ce_idle", 32'(ram_ce), 32'h0);

    // Port 0 word write then read back.
    xfer(0, 1'b1, 32'h10, 4'hF, 32'hDEADBEEF, lat);
    check("t2_wr_lat", 32'(lat), 32'd2);
    xfer(0, 1'b0, 32'h10, 4'hF, 32'h0, lat);
    check("t2_rd_lat", 32'(lat), 32'd2);
    check("t2_rdata", m0_rdata, 32'hDEADBEEF);

    // Port 1 byte-lane write over an existing word.
    xfer(1, 1'b1, 32'h20, 4'hF, 32'h11223344, lat);
    xfer(1, 1'b1, 32'h20, 4'b0010, 32'h0000AB00, lat);
    xfer(1, 1'b0, 32'h20, 4'h0, 32'h0, lat);
    check("t3_rd_lat", 32'(lat), 32'd2);
    check("t3_rdata", m1_rdata, 32'h1122AB44);

    // Port 0 drops req and changes address during ACCESS.
    req_v = 2'b00;
    tick();
    we_v[0] = 1'b0; addr_v[0] = 32'h10; sel_v[0] = 4'hF; req_v[0] = 1'b1;
    tick();
    req_v[0] = 1'b0;
    addr_v[0] = 32'h44;
    #1;
    check("t5_addr_latched", ram_addr, 32'h10);
    tick();
    check("t5_ack", 32'(m0_ack), 32'h1);
    repeat (2) tick();

    // Reset during ACCESS of a port 1 read, then a fresh port 1 read.
    we_v[1] = 1'b0; addr_v[1] = 32'h20; sel_v[1] = 4'hF; req_v[1] = 1'b1;
    tick();
    check("t6_in_access", 32'(ram_ce), 32'h1);
    rst = 1'b1;
    req_v = 2'b00;
    tick();
    check("t6_no_ack", 32'(m1_ack), 32'h0);
    rst = 1'b0;
    tick();
    check("t6_no_ack_late", 32'(m1_ack), 32'h0);
    xfer(1, 1'b0, 32'h20, 4'hF, 32'h0, lat);
    check("t6_lat", 32'(lat), 32'd2);
    check("t6_rdata", m1_rdata, 32'h1122AB44);

    // Both ports requesting continuously from reset.
    rst = 1'b1;
    we_v = 2'b00;
    addr_v[0] = 32'h10; addr_v[1] = 32'h20;
    req_v = 2'b11;
    tick();
    rst = 1'b0;
    ack_log.delete();
    repeat (12) tick();
    req_v = 2'b00;
    if (RR) exp_seq = '{0, 1, 0, 1};
    else    exp_seq = '{0, 0, 0, 0};
    check("t4_ack_count", 32'(ack_log.size()), 32'd4);
    for (int i = 0; i < 4; i++)
      check("t4_order", (ack_log.size() > i) ? 32'(ack_log[i]) : 32'hFF, 32'(exp_seq[i]));
    repeat (3) tick();

    // Randomized traffic with payload changes, req drops and resets.
    for (int n = 0; n < 400; n++) begin
      rand_drive();
      tick();
    end
    rst = 1'b0;
    req_v = 2'b00;
    repeat (4) tick();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
